// File: rtl/system_sysid_pkg.sv
// Shared types and constants for the boot-time system-ID checker.
package system_sysid_pkg;

  localparam int unsigned SYSID_DATA_W = 32;
  localparam int unsigned SYSID_WDOG_W = 16;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Must match the values baked into system_sysid by its generator script.
  localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_ID = 32'h12345678;
  localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_TS = 32'h548C83BC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_ID = 2'd1,
    ST_RD_TS = 2'd2,
    ST_DONE  = 2'd3
  } sysid_state_e;

endpackage

// File: rtl/system_sysid_watchdog.sv
// Stall counter bounding a single Avalon read; expired flags the cycle the limit is hit.
module system_sysid_watchdog
  import system_sysid_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    stall,
  input  logic [SYSID_WDOG_W-1:0] limit,
  output logic                    expired
);

  logic [SYSID_WDOG_W-1:0] count_q;

  assign expired = stall && (count_q == limit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (stall && !expired) begin
      count_q <= count_q + SYSID_WDOG_W'(1);
    end
  end

endmodule

// File: rtl/system_sysid_checker.sv
// Boot-time Avalon-MM master: reads the system-ID and timestamp words and reports pass/fail.
module system_sysid_checker
  import system_sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int unsigned             TIMEOUT_CYCLES = 255,
  parameter bit                      AUTO_START     = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  input  logic                    avm_waitrequest,
  output logic                    busy,
  output logic                    done,
  output logic                    id_ok,
  output logic                    ts_ok,
  output logic                    pass,
  output logic                    timeout,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value
);

  localparam logic [SYSID_WDOG_W-1:0] WDOG_LIMIT = SYSID_WDOG_W'(TIMEOUT_CYCLES);

  sysid_state_e            state_q, state_d;
  logic                    read_q, read_d;
  logic                    addr_q, addr_d;
  logic                    first_q;
  logic                    done_d, id_ok_d, ts_ok_d, pass_d, timeout_d;
  logic [SYSID_DATA_W-1:0] id_value_d, ts_value_d;
  logic                    wdog_expired;
  logic                    launch;

  system_sysid_watchdog u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_d != state_q),
    .stall   (avm_waitrequest && busy),
    .limit   (WDOG_LIMIT),
    .expired (wdog_expired)
  );

  // The strobe is withdrawn in the very cycle the watchdog fires; address follows to 0.
  assign avm_read    = read_q && !wdog_expired;
  assign avm_address = addr_q && !wdog_expired;

  assign launch = start || (AUTO_START && first_q);

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    addr_d     = addr_q;
    done_d     = done;
    id_ok_d    = id_ok;
    ts_ok_d    = ts_ok;
    pass_d     = pass;
    timeout_d  = timeout;
    id_value_d = id_value;
    ts_value_d = ts_value;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (launch) begin
          state_d    = ST_RD_ID;
          read_d     = 1'b1;
          addr_d     = SYSID_ADDR_ID;
          done_d     = 1'b0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = '0;
          ts_value_d = '0;
        end
      end
      ST_RD_ID: begin
        if (!avm_waitrequest) begin
          id_value_d = avm_readdata;
          state_d    = ST_RD_TS;
          addr_d     = SYSID_ADDR_TS;
        end else if (wdog_expired) begin
          state_d   = ST_DONE;
          read_d    = 1'b0;
          addr_d    = SYSID_ADDR_ID;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_RD_TS: begin
        if (!avm_waitrequest) begin
          ts_value_d = avm_readdata;
          state_d    = ST_DONE;
          read_d     = 1'b0;
          addr_d     = SYSID_ADDR_ID;
          done_d     = 1'b1;
          id_ok_d    = (id_value == EXPECTED_ID);
          ts_ok_d    = (avm_readdata == EXPECTED_TS);
          pass_d     = id_ok_d && ts_ok_d;
        end else if (wdog_expired) begin
          state_d   = ST_DONE;
          read_d    = 1'b0;
          addr_d    = SYSID_ADDR_ID;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          id_ok_d   = (id_value == EXPECTED_ID);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      read_q   <= 1'b0;
      addr_q   <= 1'b0;
      first_q  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      first_q  <= 1'b0;
      busy     <= (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
      done     <= done_d;
      id_ok    <= id_ok_d;
      ts_ok    <= ts_ok_d;
      pass     <= pass_d;
      timeout  <= timeout_d;
      id_value <= id_value_d;
      ts_value <= ts_value_d;
    end
  end

endmodule

// File: tb/tb_system_sysid_checker.sv
// Directed and randomized checks of system_sysid_checker against a latency/result model.
module tb_system_sysid_checker;

  localparam int unsigned T = 4;
  localparam logic [31:0] EXP_ID = 32'h12345678;
  localparam logic [31:0] EXP_TS = 32'h548C83BC;

  logic        clock;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, id_ok, ts_ok, pass, timeout;
  logic [31:0] id_value, ts_value;

  system_sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (T),
    .AUTO_START     (1'b1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .pass            (pass),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave model: stalls word 0 for stall0 cycles and word 1 for stall1 cycles.
  logic [31:0] id_word = EXP_ID;
  logic [31:0] ts_word = EXP_TS;
  int          stall0 = 0;
  int          stall1 = 0;
  int          scnt = 0;
  logic        widx = 1'b0;
  int          acc_total = 0;
  int          rd_cycles = 0;

  assign avm_waitrequest = widx ? (scnt < stall1) : (scnt < stall0);
  assign avm_readdata    = avm_address ? ts_word : id_word;

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) scnt <= scnt + 1;
    else scnt <= 0;
    if (avm_read && !avm_waitrequest) widx <= ~widx;
    else if (!avm_read) widx <= 1'b0;
    if (avm_read) rd_cycles <= rd_cycles + 1;
    if (avm_read && !avm_waitrequest) acc_total <= acc_total + 1;
  end

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          lat;
    int          rdc;
    int          acc;
    logic [31:0] idv;
    logic [31:0] tsv;
    logic        idok;
    logic        tsok;
    logic        to;
    logic        ps;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outcome of one check from the per-word stall counts alone.
  function automatic exp_t model(input logic [31:0] id, input logic [31:0] ts,
                                 input int s0, input int s1);
    exp_t e;
    if (s0 > int'(T)) begin
      e.lat = T + 2; e.rdc = T; e.acc = 0;
      e.idv = 0; e.tsv = 0; e.idok = 0; e.tsok = 0; e.to = 1;
    end else if (s1 > int'(T)) begin
      e.lat = s0 + 1 + T + 1 + 1; e.rdc = s0 + 1 + T; e.acc = 1;
      e.idv = id; e.tsv = 0; e.idok = (id == EXP_ID); e.tsok = 0; e.to = 1;
    end else begin
      e.lat = s0 + s1 + 3; e.rdc = s0 + s1 + 2; e.acc = 2;
      e.idv = id; e.tsv = ts; e.idok = (id == EXP_ID); e.tsok = (ts == EXP_TS); e.to = 0;
    end
    e.ps = e.idok && e.tsok && !e.to;
    return e;
  endfunction

  // Called at the negedge of the first cycle after the launching edge.
  task automatic wait_done(input string tag, input exp_t e, input int acc0, input int rc0,
                           input int pulse_k);
    int k = 1;
    while (done !== 1'b1 && k <= 40) begin
      if (avm_read === 1'b1)
        chk({tag, " addr"}, 32'(avm_address), (acc_total - acc0) >= 1 ? 32'd1 : 32'd0);
      else
        chk({tag, " addr_idle"}, 32'(avm_address), 32'd0);
      start = (k == pulse_k);
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(k), 32'(e.lat));
    chk({tag, " pass"}, 32'(pass), 32'(e.ps));
    chk({tag, " id_ok"}, 32'(id_ok), 32'(e.idok));
    chk({tag, " ts_ok"}, 32'(ts_ok), 32'(e.tsok));
    chk({tag, " timeout"}, 32'(timeout), 32'(e.to));
    chk({tag, " id_value"}, id_value, e.idv);
    chk({tag, " ts_value"}, ts_value, e.tsv);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " read_cycles"}, 32'(rd_cycles - rc0), 32'(e.rdc));
    repeat (2) @(negedge clock);
    chk({tag, " done_held"}, 32'(done), 32'd1);
    chk({tag, " read_idle"}, 32'(avm_read), 32'd0);
    chk({tag, " accepts"}, 32'(acc_total - acc0), 32'(e.acc));
  endtask

  task automatic run(input string tag, input logic [31:0] id, input logic [31:0] ts,
                     input int s0, input int s1, input int pulse_k);
    exp_t e;
    int   acc0, rc0;
    @(negedge clock);
    id_word = id; ts_word = ts; stall0 = s0; stall1 = s1;
    e = model(id, ts, s0, s1);
    acc0 = acc_total; rc0 = rd_cycles;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({tag, " cleared_done"}, 32'(done), 32'd0);
    chk({tag, " cleared_pass"}, 32'(pass), 32'd0);
    chk({tag, " cleared_timeout"}, 32'(timeout), 32'd0);
    chk({tag, " cleared_ts"}, ts_value, 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(tag, e, acc0, rc0, pulse_k);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " read"}, 32'(avm_read), 32'd0);
    chk({tag, " address"}, 32'(avm_address), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " id_ok"}, 32'(id_ok), 32'd0);
    chk({tag, " ts_ok"}, 32'(ts_ok), 32'd0);
    chk({tag, " pass"}, 32'(pass), 32'd0);
    chk({tag, " timeout"}, 32'(timeout), 32'd0);
    chk({tag, " id_value"}, id_value, 32'd0);
    chk({tag, " ts_value"}, ts_value, 32'd0);
  endtask

  initial begin
    int acc0, rc0, s0, s1;
    logic [31:0] rid, rts;
    reset = 1'b1;
    start = 1'b0;
    #1;
    chk_reset_values("reset");
    repeat (2) @(negedge clock);

    // Auto-start on the first edge after release.
    reset = 1'b0;
    acc0 = acc_total; rc0 = rd_cycles;
    @(negedge clock);
    chk("auto busy", 32'(busy), 32'd1);
    chk("auto read", 32'(avm_read), 32'd1);
    wait_done("auto", model(EXP_ID, EXP_TS, 0, 0), acc0, rc0, 0);

    run("zero_wait", EXP_ID, EXP_TS, 0, 0, 0);
    run("bad_ts", EXP_ID, 32'h548C83BD, 0, 0, 0);
    run("bad_id", 32'h12345679, EXP_TS, 0, 0, 0);
    run("stall3", EXP_ID, EXP_TS, 3, 3, 0);
    run("stall_limit", EXP_ID, EXP_TS, T, T, 0);
    run("timeout_id", EXP_ID, EXP_TS, 1000, 0, 0);
    run("timeout_ts", EXP_ID, EXP_TS, 1, 1000, 0);
    run("start_in_ts", EXP_ID, EXP_TS, 0, 3, 2);
    run("start_in_id", EXP_ID, EXP_TS, 3, 0, 2);

    // Reset in the middle of a stalled ID read.
    @(negedge clock);
    stall0 = 1000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("midreset read_before", 32'(avm_read), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_reset_values("midreset");
    @(negedge clock);
    stall0 = 0;
    reset = 1'b0;
    acc0 = acc_total; rc0 = rd_cycles;
    @(negedge clock);
    chk("midreset restart_busy", 32'(busy), 32'd1);
    chk("midreset restart_read", 32'(avm_read), 32'd1);
    wait_done("midreset", model(EXP_ID, EXP_TS, 0, 0), acc0, rc0, 0);

    for (int i = 0; i < 14; i++) begin
      rid = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      rts = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      s0 = int'($urandom_range(0, T + 1));
      s1 = int'($urandom_range(0, T + 1));
      run($sformatf("rand%0d", i), rid, rts, s0, s1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/system_sysid_checker.md
# system_sysid_checker

Boot-time Avalon-MM master that reads the two-word system-ID slave (word 0 = system ID, word 1 = build timestamp), compares both words against expected values, and reports pass/fail to the control/status logic. It sits directly upstream of `system_sysid`, driving its `address` and consuming its `readdata`. A watchdog bounds each read so a hung interconnect cannot stall the boot sequence.

## Interface
- `EXPECTED_ID`, 32'h12345678: value word 0 must return.
- `EXPECTED_TS`, 32'h548C83BC: value word 1 must return.
- `TIMEOUT_CYCLES`, 255: maximum cycles a single read may be held by waitrequest; range 1..65535.
- `AUTO_START`, 1: if 1, one check runs automatically after reset release.

Ports:
- `clock` in 1: sole clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to run a check; honoured only in IDLE or DONE.
- `avm_address` out 1: 0 = ID word, 1 = timestamp word.
- `avm_read` out 1: Avalon read strobe.
- `avm_readdata` in 32: slave read data, valid when `avm_read && !avm_waitrequest`.
- `avm_waitrequest` in 1: slave stall; tie to 0 for a zero-wait slave.
- `busy` out 1: check in progress.
- `done` out 1: level; result fields are valid.
- `id_ok` out 1: captured ID equals `EXPECTED_ID`.
- `ts_ok` out 1: captured timestamp equals `EXPECTED_TS`.
- `pass` out 1: `id_ok && ts_ok && !timeout`.
- `timeout` out 1: a read exceeded `TIMEOUT_CYCLES`.
- `id_value` out 32: captured word 0.
- `ts_value` out 32: captured word 1.

## Operation
- States: IDLE, RD_ID, RD_TS, DONE.
- IDLE: if `start`, or this is the first cycle after reset with `AUTO_START=1`, go to RD_ID and clear all result outputs.
- RD_ID: `avm_read=1`, `avm_address=0`. On `!avm_waitrequest`, capture `avm_readdata` into `id_value` and go to RD_TS.
- RD_TS: `avm_read=1`, `avm_address=1`. On `!avm_waitrequest`, capture into `ts_value` and go to DONE.
- DONE: `done=1`. `id_ok` and `ts_ok` are registered compares, updated on entry. `start` re-runs the check through RD_ID and clears `done` and all flags.
- `start` while `busy` is ignored. It is neither queued nor restarts the check.
- Watchdog:
  - A 16-bit counter clears on entry to each read state and increments each cycle `avm_waitrequest=1`.
  - When the count reaches `TIMEOUT_CYCLES` with waitrequest still high: drop `avm_read` that cycle, set `timeout=1`, and go to DONE.
  - Fields not yet read keep the value 0, and the matching `*_ok` flag is 0.
- `avm_address` and `avm_read` are held stable for the whole of each read.
- `avm_address` is 0 whenever `avm_read=0`.

## Timing
- Reset values: `avm_read=0`, `avm_address=0`, `busy=0`, `done=0`, `id_ok=0`, `ts_ok=0`, `pass=0`, `timeout=0`, `id_value=0`, `ts_value=0`. State is IDLE.
- Reset asserted mid-check: `avm_read` drops immediately (asynchronously) and everything returns to reset values.
- AUTO_START: the first check begins on the first clock edge after `reset` deasserts.
- Zero-wait latency:
  - `start` sampled at edge N.
  - RD_ID during cycle N+1.
  - RD_TS during cycle N+2.
  - `done`, `pass` and the other results are valid from cycle N+3.
  - Total: 3 cycles from `start` to `done`.
- Each waitrequest cycle adds one cycle to the read it stalls.
- Worst case: 2×(`TIMEOUT_CYCLES`+1)+1 cycles.
- `busy` is 1 in RD_ID and RD_TS only.
- `done` and the result fields are held until the next accepted `start` or reset.

## Structure
- Package `system_sysid_pkg` contains:
  - state enum;
  - `SYSID_ADDR_ID=1'b0` and `SYSID_ADDR_TS=1'b1`;
  - default expected ID and timestamp constants, shared with the `system_sysid` generator script.
- Sub-module `system_sysid_watchdog`: loadable 16-bit stall counter with a `clear` input and an `expired` output. Everything else stays in one module.

## Test plan
- Zero-wait slave returning 32'h12345678 and 32'h548C83BC, `start` at cycle 10 → address 0 in cycle 11, address 1 in cycle 12, `done=1` and `pass=1` from cycle 13.
- Word 1 returns 32'h548C83BD → `id_ok=1`, `ts_ok=0`, `pass=0`, `ts_value=32'h548C83BD`.
- Waitrequest held 3 cycles on each word → `done` asserts 9 cycles after `start`. Address and read stay stable while stalled, and `pass=1`.
- `TIMEOUT_CYCLES=4`, waitrequest stuck high on word 0 → `avm_read` drops after 4 stall cycles, with `timeout=1`, `pass=0`, `id_value=0`, and no read of word 1.
- `start` pulsed during RD_TS → ignored, and exactly one pair of reads occurs. `start` in DONE → results clear and the check repeats.
- `reset` asserted during RD_ID → `avm_read=0` with no clock edge. With `AUTO_START=1`, after release the check restarts at RD_ID on the first edge.
